// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - nibble-serial program memory loader
//
// Assembles {instruction, operand} nibble pairs from a valid/ready stream into
// program bytes and writes them to program memory at an auto-incrementing
// address. Used to load a program image before fetch is enabled.
//
// Ports:
//   clk, reset       rising-edge clock, asynchronous active-high reset
//   start, abort     begin a load (IDLE only) / cancel a load in progress
//   base_addr        first write address, sampled on an accepted start
//   length           byte count, sampled on an accepted start
//   in_valid         stream nibble valid
//   in_nibble        stream nibble
//   in_ready         loader accepts a nibble this cycle
//   wr_en            program memory write strobe
//   wr_addr          program memory write address (held when wr_en=0)
//   wr_data          program memory write data {instr, oprnd} (held when wr_en=0)
//   busy             any state other than IDLE
//   done             one-cycle pulse when a load completes normally
//   len_err          sticky: last start asked for more than 2**ADDR_W bytes
//   checksum         modulo-256 sum of bytes written by the current/last load
module prog_loader #(
  parameter int ADDR_W = 12,
  parameter int LEN_W  = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic              in_valid,
  input  logic [3:0]        in_nibble,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              done,
  output logic              len_err,
  output logic [7:0]        checksum
);

  typedef enum logic [2:0] {S_IDLE, S_HI, S_LO, S_WR, S_DONE} state_t;

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(2**ADDR_W);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  count_q, count_d;
  logic [3:0]        nib_q, nib_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic [7:0]        checksum_q, checksum_d;
  logic              len_err_q, len_err_d;
  logic              in_ready_q, in_ready_d;
  logic              wr_en_q, wr_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    count_d    = count_q;
    nib_d      = nib_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    checksum_d = checksum_q;
    len_err_d  = len_err_q;

    case (state_q)
      S_IDLE: begin
        // start beats abort here: abort is not even looked at in IDLE.
        if (start) begin
          if (length == '0) begin
            checksum_d = '0;
            len_err_d  = 1'b0;
            state_d    = S_DONE;
          end else if (length > MAX_LEN) begin
            len_err_d = 1'b1;
          end else begin
            addr_d     = base_addr;
            count_d    = length;
            checksum_d = '0;
            len_err_d  = 1'b0;
            state_d    = S_HI;
          end
        end
      end
      S_HI: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (in_valid) begin
          nib_d   = in_nibble;
          state_d = S_LO;
        end
      end
      S_LO: begin
        if (abort) begin
          nib_d   = '0;
          state_d = S_IDLE;
        end else if (in_valid) begin
          // Stage the write so it is presented, registered, in WR.
          wr_addr_d = addr_q;
          wr_data_d = {nib_q, in_nibble};
          state_d   = S_WR;
        end
      end
      S_WR: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          checksum_d = checksum_q + wr_data_q;
          addr_d     = addr_q + ADDR_W'(1);
          count_d    = count_q - LEN_W'(1);
          state_d    = (count_q == LEN_W'(1)) ? S_DONE : S_HI;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered as a decode of the next state.
    in_ready_d = (state_d == S_HI) || (state_d == S_LO);
    wr_en_d    = (state_d == S_WR);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      count_q    <= '0;
      nib_q      <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      checksum_q <= '0;
      len_err_q  <= 1'b0;
      in_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      nib_q      <= nib_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      checksum_q <= checksum_d;
      len_err_q  <= len_err_d;
      in_ready_q <= in_ready_d;
      wr_en_q    <= wr_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign in_ready = in_ready_q;
  // An abort during WR cancels the pending write in the same cycle.
  assign wr_en    = wr_en_q && !abort;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign len_err  = len_err_q;
  assign checksum = checksum_q;

endmodule
